// File: rtl/bird_input_ctrl_if.sv
// Handshake bundle between the push-button/game-control side and bird_input_ctrl.
// Master drives key_n/pause/crash/level; slave returns key/gravity/running.
// All outputs are registered in the slave; inputs other than key_n are synchronous to clk.
interface bird_input_ctrl_if;
  logic       key_n;
  logic       pause;
  logic       crash;
  logic [1:0] level;
  logic       key;
  logic       gravity;
  logic       running;

  modport master (output key_n, pause, crash, level, input key, gravity, running);
  modport slave  (input key_n, pause, crash, level, output key, gravity, running);
endinterface

// File: rtl/bird_input_ctrl.sv
// Purpose: button sync/edge-detect, level-dependent gravity tick and WAIT/RUN/HOLD flap state machine.
// Latency: key pulse on the 3rd clk edge after key_n falls (+DEB_CYCLES when DEBOUNCE_EN is defined).
// Flow: no backpressure; pause freezes state and counters, crash forces WAIT. Optional macro: DEBOUNCE_EN.
module bird_input_ctrl #(
  parameter int BASE_PERIOD = 2**24,
  parameter int CNT_W       = 25,
  parameter int HOLD_TICKS  = 2,
  parameter int DEB_CYCLES  = 2**16
) (
  input logic              clk,
  input logic              reset,
  bird_input_ctrl_if.slave bus
);

  localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(BASE_PERIOD);
  localparam logic [HW-1:0]    HOLD_CNT = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {WAIT, RUN, HOLD} state_t;

  logic sync1, sync2, filt, hist, press;

  // Two-flop synchroniser; idles released (high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.key_n;
      sync2 <= sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] deb_cnt;

  // Filtered level follows sync2 only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt    <= 1'b1;
      deb_cnt <= '0;
    end else if (sync2 == filt) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
      filt    <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  logic unused_deb;
  assign filt       = sync2;
  assign unused_deb = ^DEB_CYCLES;
`endif

  // Edge history keeps tracking in every state so a press held across pause is not seen as new.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= 1'b1;
    else       hist <= filt;
  end

  assign press = hist & ~filt;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, period;
  logic [HW-1:0]    hold, hold_nxt;
  logic [1:0]       level_q, level_nxt;
  logic             key_nxt, grav_nxt, tick;

  assign period = BASE_CNT >> level_q;
  assign tick   = (state != WAIT) && (cnt == period - 1'b1);

  // Next-state, counters and pulse decode; crash beats pause, pause beats press/tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    level_nxt = level_q;
    key_nxt   = 1'b0;
    grav_nxt  = 1'b0;
    if (bus.crash) begin
      state_nxt = WAIT;
      cnt_nxt   = '0;
      hold_nxt  = '0;
    end else if (!bus.pause) begin
      if (state != WAIT) begin
        cnt_nxt = tick ? '0 : cnt + 1'b1;
        if (tick) level_nxt = bus.level;
      end
      case (state)
        WAIT: begin
          // The bird also floats briefly after the starting flap.
          if (press) begin
            key_nxt   = 1'b1;
            cnt_nxt   = '0;
            level_nxt = bus.level;
            if (HOLD_TICKS > 0) begin
              state_nxt = HOLD;
              hold_nxt  = HOLD_CNT;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (press) begin
            key_nxt = 1'b1;
            cnt_nxt = '0;
            if (HOLD_TICKS > 0) begin
              state_nxt = HOLD;
              hold_nxt  = HOLD_CNT;
            end
          end else if (tick) begin
            grav_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (press) begin
            key_nxt  = 1'b1;
            cnt_nxt  = '0;
            hold_nxt = HOLD_CNT;
          end else if (tick) begin
            hold_nxt = hold - 1'b1;
            if (hold == HW'(1)) state_nxt = RUN;
          end
        end
        default: state_nxt = WAIT;
      endcase
    end
  end

  // State, counters and registered outputs. level_q resets to a constant; it is reloaded
  // on leaving WAIT, before any tick can use it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT;
      cnt         <= '0;
      hold        <= '0;
      level_q     <= '0;
      bus.key     <= 1'b0;
      bus.gravity <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hold        <= hold_nxt;
      level_q     <= level_nxt;
      bus.key     <= key_nxt;
      bus.gravity <= grav_nxt;
      bus.running <= (state != WAIT);
    end
  end

endmodule

// File: tb/tb_bird_input_ctrl.sv
// Directed bench for bird_input_ctrl with BASE_PERIOD=16, HOLD_TICKS=2, DEB_CYCLES=4.
// A cycle table covers the first press; hand-written sequences cover timing corner cases.
// Outputs are sampled on the falling clock edge; inputs change right after sampling.
module tb_bird_input_ctrl;
  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    logic       key_n;
    logic       pause;
    logic       crash;
    logic [1:0] level;
    logic       e_key;
    logic       e_grav;
    logic       e_run;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  bird_input_ctrl_if bus();

  bird_input_ctrl #(
    .BASE_PERIOD(16), .CNT_W(5), .HOLD_TICKS(2), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc_n = 0, key_cnt = 0, grav_cnt = 0, both_cnt = 0;
  int key_cyc = -1, grav_cyc = -1, prev_grav = -1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    if (bus.key) begin key_cnt++; key_cyc = cyc_n; end
    if (bus.gravity) begin grav_cnt++; prev_grav = grav_cyc; grav_cyc = cyc_n; end
    if (bus.key && bus.gravity) both_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_to(input int target);
    while (cyc_n < target) cyc();
  endtask

  task automatic wait_grav(input int budget);
    int start = grav_cnt;
    int n = 0;
    while (grav_cnt == start && n < budget) begin cyc(); n++; end
    if (grav_cnt == start) check("grav_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  vec_t tbl[14];

  initial begin
    int g4, k, kc0, gc0, p, t;
    for (int i = 0; i < 14; i++) begin
      tbl[i].key_n  = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].pause  = 1'b0;
      tbl[i].crash  = 1'b0;
      tbl[i].level  = 2'd0;
      tbl[i].e_key  = (i == LAT - 1);
      tbl[i].e_grav = 1'b0;
      tbl[i].e_run  = (i >= LAT);
    end

    reset = 1'b1;
    bus.key_n = 1'b1; bus.pause = 1'b0; bus.crash = 1'b0; bus.level = 2'd0;
    run(3);
    check("reset_key", bus.key, 0);
    check("reset_grav", bus.gravity, 0);
    check("reset_running", bus.running, 0);
    reset = 1'b0;

    gc0 = grav_cnt;
    run(100);
    check("idle_no_grav", grav_cnt - gc0, 0);
    check("idle_running", bus.running, 0);
    check("idle_no_key", key_cnt, 0);

    for (int i = 0; i < 14; i++) begin
      bus.key_n = tbl[i].key_n; bus.pause = tbl[i].pause;
      bus.crash = tbl[i].crash; bus.level = tbl[i].level;
      cyc();
      check($sformatf("tbl%0d_key", i), bus.key, tbl[i].e_key);
      check($sformatf("tbl%0d_grav", i), bus.gravity, tbl[i].e_grav);
      check($sformatf("tbl%0d_run", i), bus.running, tbl[i].e_run);
    end
    check("held_single_pulse", key_cnt, 1);

    wait_grav(100);
    check("first_grav_delay", grav_cyc - key_cyc, 48);
    wait_grav(100);
    check("grav_period_l0", grav_cyc - prev_grav, 16);

    run(5);
    bus.level = 2'd2;
    wait_grav(100);
    check("grav_mid_level_change", grav_cyc - prev_grav, 16);
    wait_grav(100);
    check("grav_period_l2_a", grav_cyc - prev_grav, 4);
    wait_grav(100);
    check("grav_period_l2_b", grav_cyc - prev_grav, 4);
    bus.level = 2'd0;
    wait_grav(100);
    check("grav_last_short", grav_cyc - prev_grav, 4);

    g4 = grav_cyc;
    run_to(g4 + 16 - LAT);
    bus.key_n = 1'b0;
    run(LAT);
    check("coincide_key", bus.key, 1);
    check("coincide_grav", bus.gravity, 0);
    check("coincide_no_grav_cnt", grav_cyc, g4);
    k = cyc_n;
    run(3);
    bus.key_n = 1'b1;

    run_to(k + 5);
    bus.pause = 1'b1;
    kc0 = key_cnt; gc0 = grav_cnt;
    run_to(k + 9);
    bus.key_n = 1'b0;
    run_to(k + 35);
    bus.pause = 1'b0;
    check("pause_no_key", key_cnt - kc0, 0);
    check("pause_no_grav", grav_cnt - gc0, 0);
    run_to(k + 40);
    bus.key_n = 1'b1;
    check("pause_exit_held", key_cnt - kc0, 0);
    wait_grav(100);
    check("grav_after_pause", grav_cyc - k, 78);

    bus.key_n = 1'b0;
    run(LAT);
    check("press_to_hold_key", bus.key, 1);
    p = key_cnt;
    run(2);
    bus.key_n = 1'b1;
    bus.pause = 1'b1;
    run(1);
    bus.crash = 1'b1;
    run(1);
    check("crash_key", bus.key, 0);
    check("crash_grav", bus.gravity, 0);
    check("running_lag", bus.running, 1);
    bus.crash = 1'b0;
    run(1);
    check("crash_running", bus.running, 0);
    bus.pause = 1'b0;
    gc0 = grav_cnt;
    run(60);
    check("wait_no_grav", grav_cnt - gc0, 0);
    check("wait_running", bus.running, 0);
    check("wait_no_key", key_cnt - p, 0);

    bus.key_n = 1'b0;
    run(LAT);
    check("repress_key", bus.key, 1);
    run(1);
    check("repress_running", bus.running, 1);
    bus.key_n = 1'b1;

`ifdef DEBOUNCE_EN
    run(10);
    kc0 = key_cnt;
    bus.key_n = 1'b0;
    run(2);
    bus.key_n = 1'b1;
    run(15);
    check("glitch_ignored", key_cnt - kc0, 0);
    t = cyc_n;
    bus.key_n = 1'b0;
    run(6);
    bus.key_n = 1'b1;
    run(10);
    check("deb_one_pulse", key_cnt - kc0, 1);
    check("deb_latency", key_cyc - t, 7);
`else
    t = 0;
`endif

    run(3);
    check("running_before_reset", bus.running, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_running", bus.running, 0);
    check("async_reset_key", bus.key, 0);
    check("key_grav_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
